mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares the CPU's single-ported memory between the instruction-fetch stage and the data-memory stage, which issues mem_rd/mem_wr requests for load, store, push and pop. It grants one requester at a time and holds the memory request until the memory acknowledges with mem_ready. It returns read data and a one-cycle completion pulse to the granted requester, and drives stall lines back to the pipeline. It sits between the fetch/memory stages and the external memory interface.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width
- MAX_DM_BURST, 4, consecutive data grants allowed while fetch waits (used only with MEM_ARB_STARVE_EN)

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle pulse, if_rdata valid
- dm_rd  in  1  data read request (load/pop)
- dm_wr  in  1  data write request (store/push/call)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle pulse, data access complete (read or write)
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the access this cycle
- stall_if  out  1  fetch request outstanding
- stall_dm  out  1  data request outstanding

## Operation
- FSM states: IDLE, IF_ACC, DM_ACC.
- IDLE:
  - A data request is pending when dm_rd|dm_wr. A fetch request is pending when if_req.
  - Data has priority over fetch. The selected requester's gnt is asserted combinationally in this cycle.
  - Address, write data and we (we=dm_wr) are latched. The FSM moves to the matching ACC state.
- dm_rd and dm_wr both high: treated as a write; dm_rd is ignored.
- ACC states:
  - mem_req=1; mem_addr, mem_wdata and mem_we come from the latched registers.
  - mem_req is held until mem_ready=1. At that edge mem_rdata is registered into if_rdata/dm_rdata, the matching valid pulses high for the next cycle, and the FSM returns to IDLE.
- Requesters hold req until gnt. They drop req or present a new request in the cycle after gnt.
- The IDLE cycle carrying the valid pulse may grant a new request.
- stall_x is high when x has an ungranted request, or is granted and its valid has not yet pulsed.
- stall_x is low in the valid cycle unless a new ungranted request of x is present.
- Outputs keep their last values when not valid: rdata registers are not cleared.

## Timing
- Reset values:
  - FSM IDLE; starvation counter 0.
  - All gnt, valid, stall, mem_req and mem_we are 0.
  - All address, data and rdata registers are 0.
- Minimum latency with mem_ready already high: request and gnt in cycle 0, mem_req in cycle 1, valid in cycle 2.
- Each memory wait cycle adds one cycle. There is no timeout.
- Back-to-back throughput is one access per 2 cycles when memory has zero wait.
- Reset mid-access: mem_req drops asynchronously, the access is abandoned, and no valid pulse is produced.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - A counter increments on each data grant made while if_req is pending. It clears on any fetch grant and whenever if_req=0 in IDLE.
  - When the counter equals MAX_DM_BURST, the next IDLE grant goes to fetch even if data is pending.
- Not defined: strict data priority. Fetch can starve indefinitely.

## Structure
- Shared package cpu_pkg holds:
  - the state enum arb_state_t {IDLE, IF_ACC, DM_ACC}
  - the default ADDR_W, DATA_W and MAX_DM_BURST constants
- One sub-module, mem_arb_starve_ctr: the saturating starvation counter with increment, clear and at-limit output. It is instantiated only under MEM_ARB_STARVE_EN.

## Test plan
- Single fetch, addr 0x0010, mem_ready tied 1, mem_rdata 0xDEADBEEF → if_gnt at cycle 0, mem_req at cycle 1, if_valid at cycle 2 with if_rdata=0xDEADBEEF.
- Store addr 0x0200, data 0x12345678, mem_ready delayed 3 cycles → mem_we=1 and mem_addr/mem_wdata stable for 4 cycles, dm_valid one cycle later, stall_dm high throughout.
- if_req and dm_rd raised together → dm_gnt first, if_gnt in the dm_valid cycle, stall_if high until if_valid.
- With MEM_ARB_STARVE_EN and MAX_DM_BURST=4, if_req and continuous data requests → 4 data grants, then 1 fetch grant, then data resumes. Without the macro → zero fetch grants.
- rst asserted while mem_req=1 in DM_ACC → mem_req=0 immediately, no dm_valid, FSM in IDLE, counter 0.
- dm_rd=dm_wr=1 → mem_we=1 access, dm_valid pulses, dm_rdata unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and default widths.
// Used by mem_port_arbiter and its starvation counter.
package cpu_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 32;
    localparam int MAX_DM_BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants issued while fetch waits.
// Only instantiated when MEM_ARB_STARVE_EN is defined.
module mem_arb_starve_ctr #(
    parameter int MAX = cpu_pkg::MAX_DM_BURST_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    assign at_limit = (cnt == CW'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stages, data first.
// Define MEM_ARB_STARVE_EN to force a fetch grant after MAX_DM_BURST data grants.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_DM_BURST = MAX_DM_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_dm
);

    arb_state_t state;
    arb_state_t state_nxt;

    logic              dm_pend;
    logic              grant_if;
    logic              grant_dm;
    logic              starve;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    assign dm_pend = dm_rd | dm_wr;

`ifdef MEM_ARB_STARVE_EN
    logic at_limit;
    logic ctr_inc;
    logic ctr_clr;

    assign ctr_inc = grant_dm & if_req;
    assign ctr_clr = grant_if | ((state == IDLE) & ~if_req);

    mem_arb_starve_ctr #(
        .MAX (MAX_DM_BURST)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (ctr_inc),
        .clr      (ctr_clr),
        .at_limit (at_limit)
    );

    assign starve = at_limit & if_req;
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_nxt = DM_ACC;
                end else if (grant_if) begin
                    state_nxt = IF_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are combinational so the requester sees them in its request cycle.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if (if_req && (starve || !dm_pend)) begin
                grant_if = 1'b1;
            end else if (dm_pend) begin
                grant_dm = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_valid <= (state == IF_ACC) & mem_ready;
            dm_valid <= (state == DM_ACC) & mem_ready;
            if (grant_dm) begin
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                we_q    <= dm_wr;
            end else if (grant_if) begin
                addr_q  <= if_addr;
                we_q    <= 1'b0;
            end
            if ((state == IF_ACC) && mem_ready) begin
                if_rdata <= mem_rdata;
            end
            // Writes leave the last load value in place.
            if ((state == DM_ACC) && mem_ready && !we_q) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign mem_req   = (state != IDLE);
    assign mem_we    = we_q & mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall_if  = if_req | (state == IF_ACC);
    assign stall_dm  = dm_pend | (state == DM_ACC);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Reference model tracks arbitration, memory contents and completions.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_rd = 1'b0;
    logic          dm_wr = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready = 1'b0;
    logic          stall_if;
    logic          stall_dm;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_DM_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_dm  (stall_dm)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT, indexed by the low address nibble
    logic [DW-1:0] phys_mem [16];
    // Memory as the model believes it should be
    logic [DW-1:0] ref_mem [16];

    assign mem_rdata = mem_req ? phys_mem[mem_addr[3:0]] : 32'h0BAD_0BAD;

    always @(posedge clk) begin
        if (!rst && mem_req && mem_ready && mem_we) begin
            phys_mem[mem_addr[3:0]] = mem_wdata;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          is_dm;
        logic          we;
        logic [DW-1:0] rdata;
    } item_t;

    item_t sb[$];

    // Model of the arbiter: one access outstanding at a time
    logic          out_act = 1'b0;
    logic          out_dm  = 1'b0;
    logic          out_we  = 1'b0;
    logic [AW-1:0] out_addr = '0;
    logic [DW-1:0] out_wdata = '0;
    logic          wait_v = 1'b0;
    int            burst = 0;

    always @(negedge clk) begin
        logic  dp;
        logic  gi;
        logic  gd;
        logic  lim;
        item_t it;
        if (rst) begin
            out_act = 1'b0;
            wait_v  = 1'b0;
            burst   = 0;
            sb.delete();
        end else begin
            dp = dm_rd | dm_wr;
            chk("if_valid", if_valid, wait_v && !out_dm);
            chk("dm_valid", dm_valid, wait_v && out_dm);
            if (wait_v) begin
                out_act = 1'b0;
                wait_v  = 1'b0;
            end
            chk("stall_if", stall_if, if_req || (out_act && !out_dm));
            chk("stall_dm", stall_dm, dp || (out_act && out_dm));
            gi = 1'b0;
            gd = 1'b0;
            if (!out_act) begin
                chk("mem_req_idle", mem_req, 1'b0);
`ifdef MEM_ARB_STARVE_EN
                lim = (burst >= MAXB);
`else
                lim = 1'b0;
`endif
                if (dp && !(lim && if_req)) gd = 1'b1;
                else if (if_req)            gi = 1'b1;
                chk("if_gnt", if_gnt, gi);
                chk("dm_gnt", dm_gnt, gd);
                if (gd && if_req) burst = (burst < MAXB) ? burst + 1 : burst;
                if (gi || !if_req) burst = 0;
                if (gd) begin
                    out_act   = 1'b1;
                    out_dm    = 1'b1;
                    out_we    = dm_wr;
                    out_addr  = dm_addr;
                    out_wdata = dm_wdata;
                    it.is_dm  = 1'b1;
                    it.we     = dm_wr;
                    it.rdata  = ref_mem[dm_addr[3:0]];
                    if (dm_wr) ref_mem[dm_addr[3:0]] = dm_wdata;
                    sb.push_back(it);
                end else if (gi) begin
                    out_act  = 1'b1;
                    out_dm   = 1'b0;
                    out_we   = 1'b0;
                    out_addr = if_addr;
                    it.is_dm = 1'b0;
                    it.we    = 1'b0;
                    it.rdata = ref_mem[if_addr[3:0]];
                    sb.push_back(it);
                end
            end else begin
                chk("if_gnt_busy", if_gnt, 1'b0);
                chk("dm_gnt_busy", dm_gnt, 1'b0);
                chk("mem_req", mem_req, 1'b1);
                chk("mem_addr", mem_addr, out_addr);
                chk("mem_we", mem_we, out_we);
                if (out_we) chk("mem_wdata", mem_wdata, out_wdata);
                if (mem_ready) wait_v = 1'b1;
            end
        end
    end

    // Completion monitor: pops the scoreboard whenever a valid pulses
    logic [DW-1:0] last_dm = '0;

    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            last_dm = '0;
        end else if (if_valid || dm_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty_on_valid", 1'b1, 1'b0);
            end else begin
                it = sb.pop_front();
                chk("valid_kind", {if_valid, dm_valid}, it.is_dm ? 2'b01 : 2'b10);
                if (it.is_dm && it.we) begin
                    chk("dm_rdata_hold", dm_rdata, last_dm);
                end else if (it.is_dm) begin
                    chk("dm_rdata", dm_rdata, it.rdata);
                    last_dm = it.rdata;
                end else begin
                    chk("if_rdata", if_rdata, it.rdata);
                end
            end
        end
    end

    int n_if_gnt = 0;

    // One clock of requester behaviour: hold until granted, then maybe re-request
    task automatic cycle(input int pif, input int pdm, input int prdy);
        logic g_if;
        logic g_dm;
        int   k;
        @(negedge clk);
        g_if = if_gnt;
        g_dm = dm_gnt;
        if (g_if) n_if_gnt++;
        @(posedge clk);
        #1;
        if (g_if || !if_req) begin
            if_req  = ($urandom % 100) < pif;
            if_addr = AW'($urandom);
        end
        if (g_dm || !(dm_rd || dm_wr)) begin
            k        = int'($urandom % 4);
            dm_rd    = 1'b0;
            dm_wr    = 1'b0;
            if (($urandom % 100) < pdm) begin
                dm_rd = (k != 1);
                dm_wr = (k == 1) || (k == 2);
            end
            dm_addr  = AW'($urandom);
            dm_wdata = $urandom;
        end
        mem_ready = ($urandom % 100) < prdy;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end
        #12;
        chk("rst_gnt", {if_gnt, dm_gnt}, 2'b00);
        chk("rst_valid", {if_valid, dm_valid}, 2'b00);
        chk("rst_stall", {stall_if, stall_dm}, 2'b00);
        chk("rst_mem", {mem_req, mem_we}, 2'b00);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single fetch with zero-wait memory
        phys_mem[0] = 32'hDEADBEEF;
        ref_mem[0]  = 32'hDEADBEEF;
        if_addr     = 16'h0010;
        if_req      = 1'b1;
        mem_ready   = 1'b1;
        repeat (4) cycle(0, 0, 100);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

        // Store with three wait cycles
        dm_addr   = 16'h0200;
        dm_wdata  = 32'h12345678;
        dm_wr     = 1'b1;
        mem_ready = 1'b0;
        repeat (3) cycle(0, 0, 0);
        cycle(0, 0, 100);
        repeat (3) cycle(0, 0, 100);

        // Simultaneous fetch and load: data goes first
        if_addr = 16'h0044;
        if_req  = 1'b1;
        dm_addr = 16'h0208;
        dm_rd   = 1'b1;
        repeat (7) cycle(0, 0, 100);

        // Load and store together behave as a store
        dm_addr  = 16'h0031;
        dm_wdata = 32'hA5A5_5A5A;
        dm_rd    = 1'b1;
        dm_wr    = 1'b1;
        repeat (5) cycle(0, 0, 100);

        // Randomized traffic
        repeat (1500) cycle(60, 60, 50);
        repeat (1000) cycle(80, 80, 100);

        // Fetch waiting against continuous data traffic
        repeat (6) cycle(0, 0, 100);
        n_if_gnt = 0;
        if_req   = 1'b1;
        if_addr  = 16'h0100;
        dm_rd    = 1'b1;
        repeat (40) cycle(100, 100, 100);
`ifdef MEM_ARB_STARVE_EN
        chk("starve_if_gnts", n_if_gnt > 0, 1'b1);
`else
        chk("starve_if_gnts", n_if_gnt, 0);
`endif
        repeat (8) cycle(0, 0, 100);

        // Reset while a load waits on memory
        dm_addr = 16'h0123;
        dm_rd   = 1'b1;
        mem_ready = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("pre_rst_mem_req", mem_req, 1'b1);
        #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_async_mem_req", mem_req, 1'b0);
        chk("rst_async_dm_rdata", dm_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cycle(0, 0, 100);
        chk("post_rst_dm_rdata", dm_rdata, 32'h0);

        repeat (200) cycle(50, 50, 70);
        repeat (10) cycle(0, 0, 100);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
